axi_inf_write_burst_sched: RTL and testbench

Frame-level sequencer for axi_inf_write_state_core. Takes a frame descriptor (base address, total beats) and cuts it into AXI4 INCR bursts. Each burst is capped by MAX_BURST, by the remaining beats and by the 4 KB boundary. Bursts are issued one at a time through the core's write_req/req_resp/req_done handshake, and each is gated on the write FIFO holding enough data for the whole burst.

---
 rtl/axi_inf_pkg.sv | 29 ++
 rtl/axi_inf_burst_calc.sv | 28 ++
 rtl/axi_inf_write_burst_sched.sv | 183 ++++++++++++++++++
 tb/tb_axi_inf_write_burst_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_inf_pkg.sv
// Shared types and helpers for the axi_inf burst schedulers.
//   sched_state_e : frame sequencer state encoding
//   AXI_4K_BYTES  : AXI4 burst boundary in bytes
//   min3          : smallest of three values, used for burst sizing
package axi_inf_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALC      = 3'd1,
    WAIT_DATA = 3'd2,
    REQ       = 3'd3,
    WAIT_DONE = 3'd4,
    FIN       = 3'd5
  } sched_state_e;

  localparam int unsigned AXI_4K_BYTES = 4096;

  // Smallest of three unsigned values.
  function automatic int unsigned min3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/axi_inf_burst_calc.sv
// Combinational burst sizer: beats for the next INCR burst, limited by the
// beats left in the frame, by MAX_BURST and by the distance to the next
// 4 KB boundary.
//   page_offset : cur_addr[11:0], byte offset inside the current 4 KB page
//   remain      : beats still to be written in the frame (non-zero when used)
//   blen_c      : burst length in beats, 1..MAX_BURST
module axi_inf_burst_calc
  import axi_inf_pkg::*;
#(
  parameter int unsigned LSIZE      = 10,
  parameter int unsigned CSIZE      = 24,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned BEAT_BYTES = 32
) (
  input  logic [11:0]      page_offset,
  input  logic [CSIZE-1:0] remain,
  output logic [LSIZE-1:0] blen_c
);

  int unsigned beats_to_4k_c;

  // page_offset is beat aligned, so the page always holds at least one beat.
  always_comb begin
    beats_to_4k_c = (AXI_4K_BYTES - 32'(page_offset)) / BEAT_BYTES;
    blen_c        = LSIZE'(min3(32'(remain), MAX_BURST, beats_to_4k_c));
  end

endmodule

// File: rtl/axi_inf_write_burst_sched.sv
// Frame-level write sequencer for axi_inf_write_state_core. Cuts a frame
// (base address, beat count) into AXI4 INCR bursts that respect MAX_BURST
// and the 4 KB boundary, and issues them one at a time, each only once the
// write FIFO holds the whole burst.
//   axi_aclk, axi_reset     : clock, asynchronous active-high reset
//   start, abort            : frame control pulses
//   base_addr, total_beats  : frame descriptor, latched on start
//   fifo_count              : beats available in the write FIFO
//   busy, frame_done,
//   frame_aborted           : frame status (done/aborted are 1-cycle pulses)
//   write_req, req_len,
//   req_addr                : burst request to the core (held until req_resp)
//   req_resp, req_done      : core handshake (address accepted / burst done)
module axi_inf_write_burst_sched
  import axi_inf_pkg::*;
#(
  parameter int unsigned LSIZE      = 10,
  parameter int unsigned ASIZE      = 32,
  parameter int unsigned CSIZE      = 24,
  parameter int unsigned MAX_BURST  = 256,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned DCSIZE     = 12
) (
  input  logic              axi_aclk,
  input  logic              axi_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ASIZE-1:0]  base_addr,
  input  logic [CSIZE-1:0]  total_beats,
  input  logic [DCSIZE-1:0] fifo_count,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_aborted,
  output logic              write_req,
  output logic [LSIZE-1:0]  req_len,
  output logic [ASIZE-1:0]  req_addr,
  input  logic              req_resp,
  input  logic              req_done
);

  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  sched_state_e     state_q, state_d;
  logic [ASIZE-1:0] cur_addr_q, cur_addr_d;
  logic [CSIZE-1:0] remain_q, remain_d;
  logic             abort_pend_q, abort_pend_d;
  logic             busy_d, frame_done_d, frame_aborted_d, write_req_d;
  logic [LSIZE-1:0] req_len_d;
  logic [ASIZE-1:0] req_addr_d;
  logic [LSIZE-1:0] blen_c;

  axi_inf_burst_calc #(
    .LSIZE      (LSIZE),
    .CSIZE      (CSIZE),
    .MAX_BURST  (MAX_BURST),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_burst_calc (
    .page_offset (cur_addr_q[11:0]),
    .remain      (remain_q),
    .blen_c      (blen_c)
  );

  // State and output registers.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      remain_q      <= '0;
      abort_pend_q  <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_aborted <= 1'b0;
      write_req     <= 1'b0;
      req_len       <= LSIZE'(1);
      req_addr      <= '0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remain_q      <= remain_d;
      abort_pend_q  <= abort_pend_d;
      busy          <= busy_d;
      frame_done    <= frame_done_d;
      frame_aborted <= frame_aborted_d;
      write_req     <= write_req_d;
      req_len       <= req_len_d;
      req_addr      <= req_addr_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remain_d        = remain_q;
    abort_pend_d    = abort_pend_q;
    busy_d          = busy;
    frame_done_d    = 1'b0;
    frame_aborted_d = 1'b0;
    write_req_d     = write_req;
    req_len_d       = req_len;
    req_addr_d      = req_addr;

    case (state_q)
      IDLE: begin
        // start has priority over a simultaneous abort, which is ignored here.
        if (start) begin
          abort_pend_d = 1'b0;
          if (total_beats != '0) begin
            cur_addr_d = base_addr & ~ASIZE'(BEAT_BYTES - 1);
            remain_d   = total_beats;
            busy_d     = 1'b1;
            state_d    = CALC;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end

      CALC: begin
        if (abort) begin
          frame_aborted_d = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else begin
          req_len_d  = blen_c;
          req_addr_d = cur_addr_q;
          state_d    = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        if (abort) begin
          frame_aborted_d = 1'b1;
          busy_d          = 1'b0;
          state_d         = IDLE;
        end else if (32'(fifo_count) >= 32'(req_len)) begin
          write_req_d = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        // Abort cannot cancel a burst once requested; remember it for later.
        if (abort) abort_pend_d = 1'b1;
        if (req_resp) begin
          write_req_d = 1'b0;
          state_d     = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (abort) abort_pend_d = 1'b1;
        if (req_done) begin
          cur_addr_d = cur_addr_q + (ASIZE'(req_len) << BEAT_SHIFT);
          remain_d   = remain_q - CSIZE'(req_len);
          if (abort_pend_q || abort) begin
            abort_pend_d    = 1'b0;
            frame_aborted_d = 1'b1;
            busy_d          = 1'b0;
            state_d         = IDLE;
          end else if (remain_q == CSIZE'(req_len)) begin
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end

      FIN: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        busy_d      = 1'b0;
        write_req_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_inf_write_burst_sched.sv
// Self-checking bench for axi_inf_write_burst_sched: table of frames with
// hand-derived burst shapes, hand sequences for gating/abort/reset corners,
// and random frames checked against a burst-list reference model.
module tb_axi_inf_write_burst_sched;

  localparam int unsigned LSIZE      = 10;
  localparam int unsigned ASIZE      = 32;
  localparam int unsigned CSIZE      = 24;
  localparam int unsigned MAX_BURST  = 256;
  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned DCSIZE     = 12;

  logic              axi_aclk = 1'b0;
  logic              axi_reset;
  logic              start;
  logic              abort;
  logic [ASIZE-1:0]  base_addr;
  logic [CSIZE-1:0]  total_beats;
  logic [DCSIZE-1:0] fifo_count;
  logic              busy;
  logic              frame_done;
  logic              frame_aborted;
  logic              write_req;
  logic [LSIZE-1:0]  req_len;
  logic [ASIZE-1:0]  req_addr;
  logic              req_resp;
  logic              req_done;

  axi_inf_write_burst_sched #(
    .LSIZE(LSIZE), .ASIZE(ASIZE), .CSIZE(CSIZE),
    .MAX_BURST(MAX_BURST), .BEAT_BYTES(BEAT_BYTES), .DCSIZE(DCSIZE)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_reset     (axi_reset),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .total_beats   (total_beats),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_aborted (frame_aborted),
    .write_req     (write_req),
    .req_len       (req_len),
    .req_addr      (req_addr),
    .req_resp      (req_resp),
    .req_done      (req_done)
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [31:0] addr;
    int unsigned len;
  } burst_t;

  typedef struct {
    logic [31:0] base;
    int unsigned total;
    int unsigned n;
    logic [31:0] first_addr;
    int unsigned first_len;
    int unsigned last_len;
  } vec_t;

  burst_t      exp_q[$];
  vec_t        vecs[7];
  int          n_vec = 0;
  int          n_err = 0;
  int          wr_count, done_count, abort_count;
  int unsigned len_sum, first_len, last_len;
  logic [31:0] first_addr;
  bit          wr_prev = 1'b0;
  bit          rand_fifo = 1'b0;
  bit          core_rand = 1'b0;
  int          resp_dly = 0;
  int          done_dly = 4;
  logic [DCSIZE-1:0] fifo_prev;

  // FIFO level seen by the DUT at each active edge.
  always @(posedge axi_aclk) fifo_prev = fifo_count;

  // Core model: accept the address after resp_dly cycles, finish the burst
  // done_dly cycles later.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    req_resp = 1'b0;
    req_done = 1'b0;
    forever begin
      @(negedge axi_aclk);
      req_resp = 1'b0;
      req_done = 1'b0;
      if (axi_reset === 1'b1) phase = 0;
      else begin
        case (phase)
          0: if (write_req === 1'b1) begin
               cnt = core_rand ? int'($urandom_range(0, 4)) : resp_dly;
               phase = 1;
             end
          1: if (cnt == 0) begin
               req_resp = 1'b1;
               cnt = core_rand ? int'($urandom_range(0, 6)) : done_dly;
               phase = 2;
             end else cnt--;
          2: if (cnt == 0) begin
               req_done = 1'b1;
               phase = 0;
             end else cnt--;
          default: phase = 0;
        endcase
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the burst list a frame must produce.
  function automatic void build_expected(input logic [31:0] base, input int unsigned total);
    logic [31:0] addr;
    int unsigned rem, room, len;
    exp_q.delete();
    addr = base - (base % BEAT_BYTES);
    rem  = total;
    while (rem > 0) begin
      room = (4096 - (addr % 4096)) / BEAT_BYTES;
      len  = rem;
      if (len > MAX_BURST) len = MAX_BURST;
      if (len > room) len = room;
      exp_q.push_back('{addr, len});
      addr = addr + len * BEAT_BYTES;
      rem  = rem - len;
    end
  endfunction

  // Observe requests at each falling edge.
  task automatic monitor_step();
    burst_t e;
    if (write_req === 1'b1 && !wr_prev) begin
      wr_count++;
      if (wr_count == 1) begin
        first_len  = req_len;
        first_addr = req_addr;
      end
      last_len = req_len;
      len_sum += req_len;
      check("fifo_gate", 64'(32'(fifo_prev) >= 32'(req_len)), 64'd1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected no request", req_addr, req_len);
      end else begin
        e = exp_q.pop_front();
        check("req_addr", 64'(req_addr), 64'(e.addr));
        check("req_len", 64'(req_len), 64'(e.len));
      end
    end
    if (frame_done === 1'b1) done_count++;
    if (frame_aborted === 1'b1) abort_count++;
    wr_prev = (write_req === 1'b1);
  endtask

  task automatic tick();
    @(negedge axi_aclk);
    monitor_step();
    if (rand_fifo) fifo_count = DCSIZE'($urandom_range(0, 300));
  endtask

  task automatic clear_stats();
    wr_count = 0; done_count = 0; abort_count = 0;
    len_sum = 0; first_len = 0; last_len = 0; first_addr = '0;
  endtask

  task automatic wait_end(input string name);
    int budget;
    budget = 0;
    while (done_count + abort_count == 0 && budget < 4000) begin
      tick();
      budget++;
    end
    check(name, 64'(budget < 4000), 64'd1);
    repeat (3) tick();
  endtask

  task automatic wait_wr(input logic level, input string name);
    int budget;
    budget = 0;
    while (write_req !== level && budget < 300) begin
      tick();
      budget++;
    end
    check(name, 64'(budget < 300), 64'd1);
  endtask

  task automatic run_frame(input logic [31:0] base, input int unsigned total, input bit poke);
    build_expected(base, total);
    clear_stats();
    start = 1'b1; base_addr = base; total_beats = CSIZE'(total);
    tick();
    start = 1'b0;
    if (poke) begin
      tick(); tick();
      start = 1'b1; base_addr = 32'h1234_5660; total_beats = CSIZE'(7);
      tick();
      start = 1'b0;
    end
    wait_end("frame_end_timeout");
  endtask

  initial begin
    bit saw_wr;
    logic [31:0] rb;
    int unsigned rt;

    vecs[0] = '{32'h0000_0000,  512, 4, 32'h0000_0000, 128, 128};
    vecs[1] = '{32'h0000_0F80,  300, 4, 32'h0000_0F80,   4,  40};
    vecs[2] = '{32'h0000_1000,    1, 1, 32'h0000_1000,   1,   1};
    vecs[3] = '{32'h0000_0FE0,    2, 2, 32'h0000_0FE0,   1,   1};
    vecs[4] = '{32'h0000_005F,   10, 1, 32'h0000_0040,  10,  10};
    vecs[5] = '{32'hFFFF_F000,  200, 2, 32'hFFFF_F000, 128,  72};
    vecs[6] = '{32'h0000_0000, 1000, 8, 32'h0000_0000, 128, 104};

    start = 1'b0; abort = 1'b0; base_addr = '0; total_beats = '0;
    fifo_count = DCSIZE'(4095);
    axi_reset = 1'b0;
    #1 axi_reset = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_frame_aborted", 64'(frame_aborted), 64'd0);
    check("rst_write_req", 64'(write_req), 64'd0);
    check("rst_req_len", 64'(req_len), 64'd1);
    check("rst_req_addr", 64'(req_addr), 64'd0);
    repeat (2) tick();
    axi_reset = 1'b0;
    tick();

    // Table of frames with fixed core timing and a full FIFO.
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].base, vecs[i].total, 1'b0);
      check("tbl_n_bursts", 64'(wr_count), 64'(vecs[i].n));
      check("tbl_first_addr", 64'(first_addr), 64'(vecs[i].first_addr));
      check("tbl_first_len", 64'(first_len), 64'(vecs[i].first_len));
      check("tbl_last_len", 64'(last_len), 64'(vecs[i].last_len));
      check("tbl_len_sum", 64'(len_sum), 64'(vecs[i].total));
      check("tbl_done_cnt", 64'(done_count), 64'd1);
      check("tbl_abort_cnt", 64'(abort_count), 64'd0);
      check("tbl_busy_end", 64'(busy), 64'd0);
      check("tbl_model_left", 64'(exp_q.size()), 64'd0);
    end

    // FIFO gating: 100 beats never release a 128-beat burst; 128 does, one cycle later.
    build_expected(32'h0, 256);
    clear_stats();
    fifo_count = DCSIZE'(100);
    start = 1'b1; base_addr = '0; total_beats = CSIZE'(256);
    tick();
    start = 1'b0;
    saw_wr = 1'b0;
    repeat (20) begin
      tick();
      if (write_req !== 1'b0) saw_wr = 1'b1;
    end
    check("gate_no_req", 64'(saw_wr), 64'd0);
    check("gate_busy", 64'(busy), 64'd1);
    fifo_count = DCSIZE'(128);
    check("gate_pre_edge", 64'(write_req), 64'd0);
    tick();
    check("gate_rise", 64'(write_req), 64'd1);
    wait_end("gate_timeout");
    check("gate_n_bursts", 64'(wr_count), 64'd2);
    check("gate_done_cnt", 64'(done_count), 64'd1);
    fifo_count = DCSIZE'(4095);

    // Zero-length frame.
    clear_stats();
    start = 1'b1; base_addr = 32'h100; total_beats = '0;
    tick();
    start = 1'b0;
    check("zero_done_pulse", 64'(frame_done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_cleared", 64'(frame_done), 64'd0);
    repeat (5) tick();
    check("zero_no_req", 64'(wr_count), 64'd0);

    // Abort during WAIT_DONE of burst 1 of 4.
    build_expected(32'h0, 512);
    clear_stats();
    resp_dly = 0; done_dly = 4;
    start = 1'b1; base_addr = '0; total_beats = CSIZE'(512);
    tick();
    start = 1'b0;
    wait_wr(1'b1, "abwd_req_timeout");
    wait_wr(1'b0, "abwd_resp_timeout");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_end("abwd_end_timeout");
    check("abwd_aborted", 64'(abort_count), 64'd1);
    check("abwd_no_done", 64'(done_count), 64'd0);
    check("abwd_one_req", 64'(wr_count), 64'd1);
    check("abwd_busy", 64'(busy), 64'd0);
    exp_q.delete();

    // Abort during WAIT_DATA.
    build_expected(32'h0, 64);
    clear_stats();
    fifo_count = '0;
    start = 1'b1; base_addr = '0; total_beats = CSIZE'(64);
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abwait_pulse", 64'(frame_aborted), 64'd1);
    check("abwait_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    check("abwait_no_req", 64'(wr_count), 64'd0);
    check("abwait_one_pulse", 64'(abort_count), 64'd1);
    exp_q.delete();
    fifo_count = DCSIZE'(4095);

    // Asynchronous reset while write_req is high, then a clean frame.
    build_expected(32'h0, 512);
    clear_stats();
    resp_dly = 10;
    start = 1'b1; base_addr = '0; total_beats = CSIZE'(512);
    tick();
    start = 1'b0;
    wait_wr(1'b1, "rst_req_timeout");
    #2 axi_reset = 1'b1;
    #1;
    check("midrst_write_req", 64'(write_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    axi_reset = 1'b0;
    exp_q.delete();
    resp_dly = 0;
    tick();
    run_frame(32'h0, 512, 1'b0);
    check("postrst_n_bursts", 64'(wr_count), 64'd4);
    check("postrst_done_cnt", 64'(done_count), 64'd1);
    check("postrst_model_left", 64'(exp_q.size()), 64'd0);

    // Random frames, random FIFO level and core timing, stray start while busy.
    rand_fifo = 1'b1;
    core_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rb = $urandom;
      rt = $urandom_range(1, 700);
      run_frame(rb, rt, 1'b1);
      check("rnd_len_sum", 64'(len_sum), 64'(rt));
      check("rnd_done_cnt", 64'(done_count), 64'd1);
      check("rnd_abort_cnt", 64'(abort_count), 64'd0);
      check("rnd_model_left", 64'(exp_q.size()), 64'd0);
    end
    rand_fifo = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
